// File: rtl/quo_bcd_pkg.sv
// Shared types and constants for the quotient-to-BCD converter.
// Nothing here depends on LEADING_ZERO_BLANK_EN; that macro is resolved in quo_bcd_conv.
package quo_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // 4'hF is the code the downstream 7-segment decoder shows as a dark digit.
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_adj3.sv
// Combinational add-3 correction for one BCD digit, applied before each double-dabble shift.
// Inputs never exceed 9, so the largest output is 12 and always fits in a single digit.
module bcd_adj3
  import quo_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] in_i,
  output logic [DIGIT_W-1:0] out_o
);

  assign out_o = (in_i >= ADJ_THRESH) ? (in_i + ADJ_ADD) : in_i;

endmodule

// File: rtl/quo_bcd_conv.sv
// Captures the divider quotient on start and converts it to packed BCD (shift-and-add-3).
// Define LEADING_ZERO_BLANK_EN to replace leading zero digits (above the units digit) with BLANK_CODE.
module quo_bcd_conv
  import quo_bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk_amisha,
  input  logic                      reset_amisha,
  input  logic                      start_amisha,
  input  logic [DATA_W-1:0]         bin_amisha,
  output logic                      ready_amisha,
  output logic                      done_tick_amisha,
  output logic [DIGIT_W*DIGITS-1:0] bcd_amisha
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t             state_q;
  logic [DATA_W-1:0]  binSr_q;
  logic [DATA_W-1:0]  binSr_d;
  logic [BCD_W-1:0]   bcdAcc_q;
  logic [BCD_W-1:0]   bcdAcc_d;
  logic [BCD_W-1:0]   bcdAdj;
  logic [BCD_W-1:0]   bcdOut_d;
  logic [CNT_W-1:0]   count_q;
  logic [BCD_W+DATA_W-1:0] shiftAll;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .in_i  (bcdAcc_q[g*DIGIT_W +: DIGIT_W]),
      .out_o (bcdAdj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted digits and remaining binary bits move left together; the binary MSB enters bcd bit 0.
  always_comb begin
    shiftAll = {bcdAdj, binSr_q} << 1;
    bcdAcc_d = shiftAll[BCD_W+DATA_W-1:DATA_W];
    binSr_d  = shiftAll[DATA_W-1:0];
  end

  // Output formatting applied only to the final value captured into bcd_amisha.
  always_comb begin
    bcdOut_d = bcdAcc_d;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic leading;
      leading = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (leading && (bcdAcc_d[i*DIGIT_W +: DIGIT_W] == '0)) begin
          bcdOut_d[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  // The last shift and DONE entry share one edge, so the result is captured straight from the shift path.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q          <= IDLE;
      binSr_q          <= '0;
      bcdAcc_q         <= '0;
      count_q          <= '0;
      bcd_amisha       <= '0;
      done_tick_amisha <= 1'b0;
      ready_amisha     <= 1'b1;
    end else begin
      done_tick_amisha <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_amisha) begin
            binSr_q      <= bin_amisha;
            bcdAcc_q     <= '0;
            count_q      <= CNT_W'(DATA_W);
            ready_amisha <= 1'b0;
            state_q      <= OP;
          end
        end
        OP: begin
          binSr_q  <= binSr_d;
          bcdAcc_q <= bcdAcc_d;
          count_q  <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            bcd_amisha       <= bcdOut_d;
            done_tick_amisha <= 1'b1;
            state_q          <= DONE;
          end
        end
        DONE: begin
          ready_amisha <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          ready_amisha <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quo_bcd_conv.sv
// Scoreboard bench for quo_bcd_conv: decimal reference model, directed corner cases, then random values.
// Build with LEADING_ZERO_BLANK_EN defined to check the blanked output format.
module tb_quo_bcd_conv;

  localparam int DATA_W   = 8;
  localparam int DIGITS   = 3;
  localparam int BCD_W    = 4 * DIGITS;
  localparam int MAX_WAIT = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] bin;
  logic              ready;
  logic              doneTick;
  logic [BCD_W-1:0]  bcd;

  int checkCount    = 0;
  int passCount     = 0;
  int cycleCnt      = 0;
  int doneCount     = 0;
  int expectedDones = 0;
  bit prevDone      = 1'b0;

  logic [BCD_W-1:0] expQ[$];
  int               expCycleQ[$];
  logic [BCD_W-1:0] lastResult;

  quo_bcd_conv #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk_amisha       (clk),
    .reset_amisha     (reset),
    .start_amisha     (start),
    .bin_amisha       (bin),
    .ready_amisha     (ready),
    .done_tick_amisha (doneTick),
    .bcd_amisha       (bcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Decimal digits by plain division; optional blanking of leading zeros above the units digit.
  function automatic logic [BCD_W-1:0] refBcd(input int v);
    logic [BCD_W-1:0] r;
    int  rem;
    bit  leading;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
      else leading = 1'b0;
    end
`else
    leading = 1'b0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checkCount++;
      $display("[TB] FAIL readyTimeout: ready stayed 0x%0h for %0d cycles, expected 1", ready, n);
    end
  endtask

  // Issue one start pulse at a negedge; the DUT samples it on the following posedge.
  task automatic applyStimulus(input logic [DATA_W-1:0] v, input bit expectDone);
    waitReady();
    bin   = v;
    start = 1'b1;
    if (expectDone) begin
      expQ.push_back(refBcd(int'(v)));
      expCycleQ.push_back(cycleCnt + 1 + DATA_W);
      expectedDones++;
    end
    @(negedge clk);
    start = 1'b0;
    bin   = DATA_W'($urandom);
  endtask

  // Monitor: every done tick is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (doneTick === 1'b1) begin
      doneCount++;
      checkOutput("doneWidth", 32'(prevDone), 32'd0);
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedDone: got done_tick with bcd 0x%0h, expected no done_tick", bcd);
      end else begin
        logic [BCD_W-1:0] e;
        int c;
        e = expQ.pop_front();
        c = expCycleQ.pop_front();
        checkOutput("bcd", 32'(bcd), 32'(e));
        checkOutput("latency", 32'(cycleCnt), 32'(c));
        lastResult = e;
      end
    end
    prevDone = (doneTick === 1'b1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d/%0d checks", passCount, checkCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lowCycles;
    int n;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    lastResult = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("resetReady", 32'(ready), 32'd1);
    checkOutput("resetDone", 32'(doneTick), 32'd0);
    checkOutput("resetBcd", 32'(bcd), 32'd0);

    // Quotient of 35/7, as delivered by the divider's done tick.
    applyStimulus(8'd5, 1'b1);

    applyStimulus(8'd255, 1'b1);
    lowCycles = 0;
    n = 0;
    while (ready === 1'b0 && n < MAX_WAIT) begin
      lowCycles++;
      @(negedge clk);
      n++;
    end
    checkOutput("readyLowCycles", 32'(lowCycles), 32'(DATA_W + 1));

    applyStimulus(8'd0, 1'b1);
    applyStimulus(8'd99, 1'b1);

    // A start pulse during OP must be ignored and the old result must stay visible.
    applyStimulus(8'd200, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("holdDuringOp", 32'(bcd), 32'(lastResult));
    checkOutput("readyDuringOp", 32'(ready), 32'd0);
    bin   = 8'd17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a conversion aborts it without a done tick.
    applyStimulus(8'd128, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    lastResult = '0;
    checkOutput("abortReady", 32'(ready), 32'd1);
    checkOutput("abortBcd", 32'(bcd), 32'd0);
    checkOutput("abortDone", 32'(doneTick), 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("abortStaysIdle", 32'(ready), 32'd1);
    applyStimulus(8'd128, 1'b1);

    for (int k = 0; k < 24; k++) begin
      logic [DATA_W-1:0] v;
      v = DATA_W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(v, 1'b1);
    end

    n = 0;
    while (expQ.size() > 0 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("pendingResults", 32'(expQ.size()), 32'd0);
    checkOutput("doneCount", 32'(doneCount), 32'(expectedDones));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
